// File: rtl/clk_disp_pkg.sv
// rtl/clk_disp_pkg.sv - shared constants and types for the 6-digit scanned clock display
// Contents:
//   NUM_DIGITS          number of multiplexed digit slots
//   SEG_0..SEG_9        active-low {g,f,e,d,c,b,a} codes for decimal digits
//   SEG_DASH, SEG_BLANK codes for an invalid nibble and for a dark digit
//   slot_t, SLOT_*      digit-slot index type and slot names
package clk_disp_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [2:0] slot_t;

  localparam slot_t SLOT_SEC_U = 3'd0;
  localparam slot_t SLOT_SEC_T = 3'd1;
  localparam slot_t SLOT_MIN_U = 3'd2;
  localparam slot_t SLOT_MIN_T = 3'd3;
  localparam slot_t SLOT_HR_U  = 3'd4;
  localparam slot_t SLOT_HR_T  = 3'd5;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD nibble to active-low 7-segment decoder
// Ports:
//   nibble  in  4  BCD digit; values above 9 decode to a dash
//   seg     out 7  active-low {g,f,e,d,c,b,a}
module bcd_to_seg7
  import clk_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// rtl/bcd_scan_display.sv - 6-digit multiplexed common-anode display driver for hh:mm:ss BCD
// Ports:
//   clk       in  1  system clock, rising edge
//   rst_n     in  1  asynchronous active-low reset
//   sec_bcd   in  8  seconds {tens, units}
//   min_bcd   in  8  minutes {tens, units}
//   hour_bcd  in  8  hours {tens, units}
//   blink_en  in  1  separator dots blink when set, steady on when clear
//   hbz_en    in  1  blank the hour-tens digit when it is zero
//   seg       out 8  active-low {dp, g, f, e, d, c, b, a}
//   an        out 6  active-low digit enables, an[i] = slot i
module bcd_scan_display
  import clk_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int GHOST_CYC    = 8,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sec_bcd,
  input  logic [7:0] min_bcd,
  input  logic [7:0] hour_bcd,
  input  logic       blink_en,
  input  logic       hbz_en,
  output logic [7:0] seg,
  output logic [5:0] an
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GHOST_END  = PW'(GHOST_CYC);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam slot_t         LAST_SLOT  = slot_t'(NUM_DIGITS - 1);

  logic [PW-1:0] presc;
  slot_t         idx;
  logic [BW-1:0] blink_cnt;
  logic          dot_phase;
  logic [23:0]   shadow;

  logic          slot_end;
  logic          frame_wrap;
  logic [3:0]    nibble;
  logic [6:0]    dec_seg;
  logic [6:0]    digit_seg;
  logic          dp_n;
  logic          ghost;
  logic [5:0]    an_next;
  logic [7:0]    seg_next;

  assign slot_end   = (presc == PRESC_LAST);
  assign frame_wrap = slot_end && (idx == LAST_SLOT);

  // Scan timing, frame snapshot and blink phase. The snapshot, index wrap and
  // blink update share the frame-wrap edge so slot 0 of a new frame always
  // shows the freshly captured time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      idx       <= SLOT_SEC_U;
      blink_cnt <= '0;
      dot_phase <= 1'b1;
      shadow    <= '0;
    end else begin
      presc <= slot_end ? '0 : presc + 1'b1;
      if (slot_end) begin
        idx <= (idx == LAST_SLOT) ? SLOT_SEC_U : idx + 3'd1;
      end
      if (frame_wrap) begin
        shadow <= {hour_bcd, min_bcd, sec_bcd};
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          dot_phase <= ~dot_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    nibble = 4'h0;
    case (idx)
      SLOT_SEC_U: nibble = shadow[3:0];
      SLOT_SEC_T: nibble = shadow[7:4];
      SLOT_MIN_U: nibble = shadow[11:8];
      SLOT_MIN_T: nibble = shadow[15:12];
      SLOT_HR_U:  nibble = shadow[19:16];
      SLOT_HR_T:  nibble = shadow[23:20];
      default:    nibble = 4'h0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    digit_seg = dec_seg;
    if (hbz_en && (idx == SLOT_HR_T) && (nibble == 4'h0)) begin
      digit_seg = SEG_BLANK;
    end
    // Dots sit after the hour-units and minute-units digits; blink_en=0
    // overrides the phase without disturbing the frame counter.
    dp_n = ~(((idx == SLOT_MIN_U) || (idx == SLOT_HR_U)) && (dot_phase || !blink_en));
    // All anodes off for the first cycles of a slot so the previous digit's
    // segments have settled before the next anode turns on.
    ghost    = (presc < GHOST_END);
    an_next  = ghost ? 6'h3F : ~(6'b000001 << idx);
    seg_next = ghost ? 8'hFF : {dp_n, digit_seg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 6'h3F;
      seg <= 8'hFF;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb/tb_bcd_scan_display.sv - directed self-checking bench for bcd_scan_display
module tb_bcd_scan_display;

  localparam int RD = 4;
  localparam int GC = 1;
  localparam int BF = 2;

  logic       clk;
  logic       rst_n;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic [7:0] hour_bcd;
  logic       blink_en;
  logic       hbz_en;
  logic [7:0] seg;
  logic [5:0] an;

  int checks;
  int failures;
  int frame_no;

  bcd_scan_display #(
    .REFRESH_DIV  (RD),
    .GHOST_CYC    (GC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sec_bcd  (sec_bcd),
    .min_bcd  (min_bcd),
    .hour_bcd (hour_bcd),
    .blink_en (blink_en),
    .hbz_en   (hbz_en),
    .seg      (seg),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full frame (24 clocks), checked at every negedge. exp[s] is the
  // 7-bit code expected in slot s. Optionally changes sec_bcd during slot 2.
  task automatic run_frame(input logic [5:0][6:0] exp, input bit mid, input logic [7:0] mid_sec);
    logic       lit;
    logic       dp;
    logic [5:0] an_e;
    logic [7:0] seg_e;
    lit = !blink_en || (((frame_no / BF) % 2) == 0);
    for (int s = 0; s < 6; s++) begin
      for (int c = 0; c < RD; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (c < GC) begin
          an_e  = 6'h3F;
          seg_e = 8'hFF;
        end else begin
          dp    = !(((s == 2) || (s == 4)) && lit);
          an_e  = ~(6'b000001 << s);
          seg_e = {dp, exp[s]};
        end
        check($sformatf("f%0d_s%0d_c%0d an_seg", frame_no, s, c), {18'h0, an, seg}, {18'h0, an_e, seg_e});
        if (mid && s == 2 && c == 0) sec_bcd = mid_sec;
      end
    end
    frame_no++;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    frame_no = 0;
    rst_n    = 1'b0;
    hour_bcd = 8'h23;
    min_bcd  = 8'h59;
    sec_bcd  = 8'h58;
    blink_en = 1'b1;
    hbz_en   = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_an", {26'h0, an}, 32'h3F);
    check("reset_seg", {24'h0, seg}, 32'hFF);
    rst_n = 1'b1;

    // f0: shadow still zero
    run_frame({7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0, 8'h00);
    // f1: 23:59:58, seconds change to 59 during slot 2
    run_frame({7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h00}, 1'b1, 8'h59);
    // f2: 23:59:59, dots now dark
    hour_bcd = 8'h07;
    hbz_en   = 1'b1;
    sec_bcd  = 8'hA3;
    run_frame({7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10}, 1'b0, 8'h00);
    // f3: 07:59:A3 with leading-zero blank, dash in seconds tens
    run_frame({7'h7F, 7'h78, 7'h12, 7'h10, 7'h3F, 7'h30}, 1'b0, 8'h00);
    // f4..f6: no blanking, dots forced on
    hbz_en   = 1'b0;
    blink_en = 1'b0;
    run_frame({7'h40, 7'h78, 7'h12, 7'h10, 7'h3F, 7'h30}, 1'b0, 8'h00);
    run_frame({7'h40, 7'h78, 7'h12, 7'h10, 7'h3F, 7'h30}, 1'b0, 8'h00);
    run_frame({7'h40, 7'h78, 7'h12, 7'h10, 7'h3F, 7'h30}, 1'b0, 8'h00);
    // f7: blinking again; frame counter kept running so dots are dark here
    blink_en = 1'b1;
    run_frame({7'h40, 7'h78, 7'h12, 7'h10, 7'h3F, 7'h30}, 1'b0, 8'h00);

    // Reset mid-frame
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_an", {26'h0, an}, 32'h3F);
    check("midrst_seg", {24'h0, seg}, 32'hFF);
    repeat (2) @(negedge clk);
    check("midrst_hold_an", {26'h0, an}, 32'h3F);
    rst_n    = 1'b1;
    frame_no = 0;
    run_frame({7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Downstream consumer of the BCD minute/second counters and the hour counter in the digital-clock datapath.
- Takes three packed-BCD bytes (hh, mm, ss) and drives a 6-digit multiplexed common-anode 7-segment display.
- Snapshots inputs once per scan frame so a counter rollover mid-frame never shows a torn time.
- Provides anti-ghosting blanking, blinking separator dots and dash display for invalid BCD.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit slot; legal range ≥ 2.
- GHOST_CYC, 8: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.
- BLINK_FRAMES, 64: full scan frames per separator-dot toggle when blinking.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sec_bcd  in  8  seconds, {tens, units} BCD.
- min_bcd  in  8  minutes, {tens, units} BCD.
- hour_bcd  in  8  hours, {tens, units} BCD.
- blink_en  in  1  1 = separator dots blink; 0 = dots steady on.
- hbz_en  in  1  1 = blank the hour-tens digit when it is 0.
- seg  out  8  active-low; bit7 = dp, bits6..0 = g,f,e,d,c,b,a.
- an  out  6  active-low digit enables; an[i] selects digit slot i.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - prescaler=0, digit index=0, blink counter=0, dot phase=1.
  - Shadow registers cleared to 0.
  - an=6'h3F (all off), seg=8'hFF.
- Reset release: the first slot is index 0, showing shadow data (zeros) until the first frame snapshot.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - slot_end is asserted on the cycle it equals REFRESH_DIV-1.
- Digit index:
  - Advances on slot_end and wraps 5→0.
  - Slot map: 0 = sec units, 1 = sec tens, 2 = min units, 3 = min tens, 4 = hour units, 5 = hour tens.
- Snapshot:
  - On slot_end with index==5, i.e. on frame wrap, shadow ← {hour_bcd, min_bcd, sec_bcd}.
  - Inputs are sampled on that edge only. Input changes at any other time are invisible until the next frame.
- Blink:
  - Frame counter increments at each frame wrap.
  - When it reaches BLINK_FRAMES-1, it clears and dot phase toggles.
  - blink_en=0 forces the effective phase to 1, but the counter keeps running.
- Outputs are registered:
  - an and seg reflect the current index and prescaler value one cycle later. Latency from an index change to the new an/seg is 1 clk.
  - While the prescaler is < GHOST_CYC: an=6'h3F, seg=8'hFF.
  - Otherwise: an = ~(1<<index); seg[6:0] = decode(selected nibble).
  - seg[7] = 0 (lit) only when index is 2 or 4 and the effective phase is 1; else 1.
- Decode, active-low:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10.
  - Nibble > 9 shows a dash, 7'h3F.
- Leading-zero blank: with hbz_en=1, index 5 and hour-tens nibble == 0, seg[6:0]=7'h7F. The anode is still driven, and dp follows the normal rule.
- Simultaneous events: the snapshot, index wrap and blink update all happen on the same slot_end edge. The new frame's slot 0 uses the new shadow.
- Reset mid-frame: immediate return to reset values; no partial-frame output afterwards.

Decomposition:
- Shared package clk_disp_pkg:
  - SEG_* constants for digits 0-9, SEG_DASH=7'h3F, SEG_BLANK=7'h7F.
  - NUM_DIGITS=6.
  - Digit-slot index type (3-bit) and slot-name constants (SLOT_SEC_U … SLOT_HR_T).
- Sub-module bcd_to_seg7: combinational nibble → 7-bit active-low code, including the dash for invalid values; instantiated once on the mux output.

Test Plan (REFRESH_DIV=4, GHOST_CYC=1, BLINK_FRAMES=2):
- Reset hold, then release with inputs 23:59:58 → during reset an=3F, seg=FF. In the first frame (pre-snapshot) every digit shows seg[6:0]=40. Next frame: slot 0 (an=3E) seg[6:0]=00, slot 1 seg[6:0]=12, slot 5 (an=1F) seg[6:0]=24.
- Each slot → cycle 0 shows an=3F, seg=FF; cycles 1-3 show a steady selected anode. One full frame is 24 clk.
- Change sec_bcd 8'h58→8'h59 mid-frame (during slot 2) → slots 0/1 are unchanged for the rest of that frame. The next frame's slot 0 shows seg[6:0]=10.
- hour_bcd=8'h07 with hbz_en=1 → slot 5 seg[6:0]=7F, slot 4 seg[6:0]=78. With hbz_en=0 → slot 5 seg[6:0]=40.
- sec_bcd=8'hA3 → slot 1 seg[6:0]=3F (dash), slot 0 seg[6:0]=30.
- blink_en=1 → seg[7] in slots 2/4 is 0 for 2 frames, then 1 for 2 frames, repeating. Slots 0,1,3,5 always have seg[7]=1. blink_en=0 → seg[7]=0 in slots 2/4 every frame.
